fetch_queue: RTL and testbench
==============================

# fetch_queue

First-word-fall-through instruction queue between the fetch stage and decode. It absorbs decode stalls without losing fetched words and freezes fetch when full. It drops fetch bubbles (instr == 0) and discards wrong-path words on flush or halt. It decouples the icache/BTB timing from scoreboard stall timing.

## Interface
Parameters:
- DEPTH, 4, entry count; power of two, ≥ 2
- Entry/word widths come from isa_pkg::word_t (32 bits)

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- fq_in_pc  in  32  PC from fetch stage
- fq_in_instr  in  32  instruction from fetch stage; 0 means bubble
- fq_in_pred  in  1  BTB predicted_outcome for this word
- fq_flush  in  1  redirect: (update_btb && misprediction) || jump
- fq_halt  in  1  halt; level, held by upstream
- dec_ready  in  1  decode accepts head this cycle (scoreboard not stalling)
- fq_freeze  out  1  to fetch freeze; high when the queue is full
- dec_valid  out  1  head entry is valid for decode
- dec_pc  out  32  head PC; 0 when !dec_valid
- dec_instr  out  32  head instruction; 0 when !dec_valid
- dec_pred  out  1  head prediction; 0 when !dec_valid
- fq_count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Storage: DEPTH × fq_entry_t; rd_ptr/wr_ptr are $clog2(DEPTH)+1 bits with a wrap bit.
- empty = (rd_ptr == wr_ptr). full = index bits equal and wrap bits differ.
- enq = (fq_in_instr != 0) && !full && !fq_flush && !fq_halt.
- deq = dec_valid && dec_ready.
- dec_valid = !empty && !fq_flush && !fq_halt.
- When dec_valid is low, dec_pc, dec_instr and dec_pred are forced to 0 (bubble convention).
- fq_freeze = full. It is derived from registered pointers only and has no combinational path from dec_ready.
  - When full, fetch re-presents the same word in the following cycles until freeze drops.
  - When full and deq, only the dequeue occurs that cycle. The re-presented word enqueues the next cycle.
- Simultaneous enq and deq on a non-full, non-empty queue: both happen and occupancy is unchanged.
- fq_flush:
  - At the next edge, rd_ptr <= wr_ptr (queue emptied) and the incoming word is dropped.
  - Storage contents are not cleared.
- fq_halt: same effect as flush, applied every cycle while asserted. The queue stays empty and dec_valid stays 0.
- Flush and halt together behave as halt.
- fq_count = wr_ptr − rd_ptr, modulo 2^($clog2(DEPTH)+1).

## Timing
- Reset (async): rd_ptr = wr_ptr = 0, fq_count = 0, fq_freeze = 0, dec_valid = 0, dec_* = 0.
- Reset mid-operation discards all entries immediately, without waiting for the clock.
- Enqueue-to-head latency is 1 cycle. A word enqueued at edge t appears on dec_* after edge t when the queue was empty. There is no same-cycle bypass.
- Throughput is 1 enqueue and 1 dequeue per cycle.
- fq_freeze rises the cycle after the DEPTH-th enqueue edge. It falls the cycle after the first dequeue from full.
- Flush issued in cycle t:
  - dec_valid is 0 in cycle t.
  - The queue is empty after edge t.
  - The first post-flush word is accepted in cycle t+1 at the earliest.
- Pointer wrap: index bits roll over from DEPTH−1 to 0 and the wrap bit toggles. Ordering is preserved across the wrap.

## Structure
- Add to isa_pkg: typedef struct packed { word_t pc; word_t instr; logic pred; } fq_entry_t.
- Add fetch_queue_if.vh with modports fq (this block), fs (fetch side) and dec (decode side).
- One flat module, fetch_queue. Storage is an array of fq_entry_t plus the pointer registers. No sub-module is required.
- Top-level wiring:
  - fetch_stage fsif.freeze = scoreboard_freeze || fq_freeze.
  - fq_in_* connect to fsif.pc, fsif.instr and fsif.predicted_outcome.

## Test plan
- Reset and bubbles: after reset drive instr = 0 for 3 cycles. Expect dec_valid = 0, fq_count = 0, fq_freeze = 0 throughout.
- Streaming: with dec_ready = 1, push PC 0x100/0x104/0x108 with instrs 0x11/0x22/0x33. Expect the same sequence on dec_* 1 cycle later, and fq_count never above 1.
- Fill and freeze: with dec_ready = 0, push 4 words. Expect fq_count = 4 and fq_freeze = 1. Then hold the 5th word (0x110) for 2 cycles, set dec_ready = 1, and check:
  - the 5th word is not lost;
  - output order is 0x100, 0x104, 0x108, 0x10C, 0x110.
- Flush with entries: with 3 entries queued, assert fq_flush for 1 cycle while presenting 0x200. Expect dec_valid = 0 that cycle and fq_count = 0 next. A following push of 0x300 emerges as the next head.
- Wrap-around: run 10 enqueue/dequeue pairs with randomized dec_ready gaps. Expect in-order output across the pointer wrap and fq_count matching the model.
- Halt and async reset:
  - Assert fq_halt while 2 entries are queued and keep pushing. Expect dec_valid = 0 and fq_count = 0 while halt is held.
  - Pulse nRST low mid-clock with entries queued. Expect all outputs 0 immediately.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared word and queue-entry types for the fetch queue
package fetch_queue_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    typedef struct packed {
        word_t pc;
        word_t instr;
        logic  pred;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch/decode handshake bundle around the fetch queue
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    import fetch_queue_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    word_t          fq_in_pc;
    word_t          fq_in_instr;
    logic           fq_in_pred;
    logic           fq_flush;
    logic           fq_halt;
    logic           dec_ready;
    logic           fq_freeze;
    logic           dec_valid;
    word_t          dec_pc;
    word_t          dec_instr;
    logic           dec_pred;
    logic [CW-1:0]  fq_count;

    modport fq (
        input  fq_in_pc, fq_in_instr, fq_in_pred, fq_flush, fq_halt, dec_ready,
        output fq_freeze, dec_valid, dec_pc, dec_instr, dec_pred, fq_count
    );

    modport fs (
        output fq_in_pc, fq_in_instr, fq_in_pred,
        input  fq_freeze
    );

    modport dec (
        input  dec_valid, dec_pc, dec_instr, dec_pred, fq_count,
        output dec_ready
    );

endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - first-word-fall-through queue between fetch and decode
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       CLK,
    input  logic       nRST,
    fetch_queue_if.fq  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    fq_entry_t          mem [DEPTH];
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic               empty;
    logic               full;
    logic               drop;
    logic               enq;
    logic               deq;
    fq_entry_t          head;
    fq_entry_t          in_entry;

    assign empty = (rd_ptr == wr_ptr);
    assign full  = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);

    // Flush and halt share one path; halt simply keeps it asserted.
    assign drop  = bus.fq_flush || bus.fq_halt;
    assign enq   = (bus.fq_in_instr != '0) && !full && !drop;

    assign bus.dec_valid = !empty && !drop;
    assign deq           = bus.dec_valid && bus.dec_ready;

    assign head     = mem[rd_ptr[AW-1:0]];
    assign in_entry = '{pc: bus.fq_in_pc, instr: bus.fq_in_instr, pred: bus.fq_in_pred};

    assign bus.dec_pc    = bus.dec_valid ? head.pc    : '0;
    assign bus.dec_instr = bus.dec_valid ? head.instr : '0;
    assign bus.dec_pred  = bus.dec_valid ? head.pred  : 1'b0;

    assign bus.fq_freeze = full;
    assign bus.fq_count  = wr_ptr - rd_ptr;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (drop) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is left uncleared on reset/flush; the pointers alone define validity.
    always_ff @(posedge CLK) begin
        if (enq) mem[wr_ptr[AW-1:0]] <= in_entry;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed table plus randomized model check of fetch_queue
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = 4;

    logic CLK = 1'b0;
    logic nRST = 1'b0;

    fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        word_t pc;
        word_t instr;
        logic  pred;
        logic  flush;
        logic  halt;
        logic  ready;
        logic  e_valid;
        word_t e_pc;
        word_t e_instr;
        logic  e_pred;
        int    e_count;
        logic  e_freeze;
    } vec_t;

    vec_t      tab[$];
    fq_entry_t model_q[$];
    int        n_vec = 0;
    int        n_mis = 0;

    function automatic vec_t mk(word_t pc, word_t instr, logic fl, logic ha, logic rdy,
                                logic ev, word_t epc, word_t ein, int ecnt, logic efrz);
        vec_t v;
        v.pc = pc; v.instr = instr; v.pred = pc[2];
        v.flush = fl; v.halt = ha; v.ready = rdy;
        v.e_valid = ev; v.e_pc = epc; v.e_instr = ein; v.e_pred = ev & epc[2];
        v.e_count = ecnt; v.e_freeze = efrz;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ev, input word_t epc, input word_t ein,
                           input logic ep, input int ecnt, input logic efrz);
        chk({tag, ".dec_valid"}, 64'(bus.dec_valid), 64'(ev));
        chk({tag, ".dec_pc"},    64'(bus.dec_pc),    64'(epc));
        chk({tag, ".dec_instr"}, 64'(bus.dec_instr), 64'(ein));
        chk({tag, ".dec_pred"},  64'(bus.dec_pred),  64'(ep));
        chk({tag, ".fq_count"},  64'(bus.fq_count),  64'(ecnt));
        chk({tag, ".fq_freeze"}, 64'(bus.fq_freeze), 64'(efrz));
    endtask

    task automatic drive(input word_t pc, input word_t instr, input logic pred,
                         input logic fl, input logic ha, input logic rdy);
        bus.fq_in_pc    = pc;
        bus.fq_in_instr = instr;
        bus.fq_in_pred  = pred;
        bus.fq_flush    = fl;
        bus.fq_halt     = ha;
        bus.dec_ready   = rdy;
    endtask

    // Queue semantics from the block's rules: drop empties, dequeue head if presented
    // and accepted, append non-bubble words only when there was room before the edge.
    task automatic model_edge();
        bit had_room;
        bit take;
        if (bus.fq_flush || bus.fq_halt) begin
            model_q.delete();
        end else begin
            had_room = (model_q.size() < DEPTH);
            take     = (model_q.size() > 0) && bus.dec_ready;
            if (take) void'(model_q.pop_front());
            if (bus.fq_in_instr != 0 && had_room)
                model_q.push_back('{pc: bus.fq_in_pc, instr: bus.fq_in_instr, pred: bus.fq_in_pred});
        end
    endtask

    task automatic model_check(input string tag);
        logic  ev;
        word_t epc;
        word_t ein;
        logic  ep;
        ev  = (model_q.size() > 0) && !bus.fq_flush && !bus.fq_halt;
        epc = ev ? model_q[0].pc    : '0;
        ein = ev ? model_q[0].instr : '0;
        ep  = ev ? model_q[0].pred  : 1'b0;
        chk_all(tag, ev, epc, ein, ep, model_q.size(), model_q.size() == DEPTH);
    endtask

    initial begin
        drive('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        #12;
        chk_all("reset", 1'b0, '0, '0, 1'b0, 0, 1'b0);
        @(negedge CLK);
        nRST = 1'b1;

        // reset and bubbles
        for (int i = 0; i < 3; i++) tab.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        // streaming
        tab.push_back(mk(32'h100, 32'h11, 0, 0, 1, 0, 0, 0, 0, 0));
        tab.push_back(mk(32'h104, 32'h22, 0, 0, 1, 1, 32'h100, 32'h11, 1, 0));
        tab.push_back(mk(32'h108, 32'h33, 0, 0, 1, 1, 32'h104, 32'h22, 1, 0));
        tab.push_back(mk(0, 0, 0, 0, 1, 1, 32'h108, 32'h33, 1, 0));
        tab.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        // fill, freeze, hold fifth word, drain
        tab.push_back(mk(32'h100, 32'h1100, 0, 0, 0, 0, 0, 0, 0, 0));
        tab.push_back(mk(32'h104, 32'h1104, 0, 0, 0, 1, 32'h100, 32'h1100, 1, 0));
        tab.push_back(mk(32'h108, 32'h1108, 0, 0, 0, 1, 32'h100, 32'h1100, 2, 0));
        tab.push_back(mk(32'h10C, 32'h110C, 0, 0, 0, 1, 32'h100, 32'h1100, 3, 0));
        tab.push_back(mk(32'h110, 32'h1110, 0, 0, 0, 1, 32'h100, 32'h1100, 4, 1));
        tab.push_back(mk(32'h110, 32'h1110, 0, 0, 0, 1, 32'h100, 32'h1100, 4, 1));
        tab.push_back(mk(32'h110, 32'h1110, 0, 0, 1, 1, 32'h100, 32'h1100, 4, 1));
        tab.push_back(mk(32'h110, 32'h1110, 0, 0, 1, 1, 32'h104, 32'h1104, 3, 0));
        tab.push_back(mk(0, 0, 0, 0, 1, 1, 32'h108, 32'h1108, 3, 0));
        tab.push_back(mk(0, 0, 0, 0, 1, 1, 32'h10C, 32'h110C, 2, 0));
        tab.push_back(mk(0, 0, 0, 0, 1, 1, 32'h110, 32'h1110, 1, 0));
        tab.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        // flush with three entries
        tab.push_back(mk(32'h180, 32'h2180, 0, 0, 0, 0, 0, 0, 0, 0));
        tab.push_back(mk(32'h184, 32'h2184, 0, 0, 0, 1, 32'h180, 32'h2180, 1, 0));
        tab.push_back(mk(32'h188, 32'h2188, 0, 0, 0, 1, 32'h180, 32'h2180, 2, 0));
        tab.push_back(mk(32'h200, 32'h2200, 1, 0, 0, 0, 0, 0, 3, 0));
        tab.push_back(mk(32'h300, 32'h2300, 0, 0, 1, 0, 0, 0, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 1, 1, 32'h300, 32'h2300, 1, 0));
        // halt while pushing, then halt with flush
        tab.push_back(mk(32'h400, 32'h2400, 0, 0, 0, 0, 0, 0, 0, 0));
        tab.push_back(mk(32'h404, 32'h2404, 0, 0, 0, 1, 32'h400, 32'h2400, 1, 0));
        tab.push_back(mk(32'h408, 32'h2408, 0, 1, 0, 0, 0, 0, 2, 0));
        tab.push_back(mk(32'h40C, 32'h240C, 0, 1, 0, 0, 0, 0, 0, 0));
        tab.push_back(mk(32'h410, 32'h2410, 1, 1, 1, 0, 0, 0, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));

        for (int i = 0; i < tab.size(); i++) begin
            drive(tab[i].pc, tab[i].instr, tab[i].pred, tab[i].flush, tab[i].halt, tab[i].ready);
            #1;
            chk_all($sformatf("row%0d", i), tab[i].e_valid, tab[i].e_pc, tab[i].e_instr,
                    tab[i].e_pred, tab[i].e_count, tab[i].e_freeze);
            @(posedge CLK);
            model_edge();
            @(negedge CLK);
        end

        // randomized traffic across many pointer wraps
        for (int i = 0; i < 400; i++) begin
            word_t w;
            w = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom | 32'h1);
            drive($urandom, w, 1'($urandom), $urandom_range(0, 24) == 0,
                  $urandom_range(0, 39) == 0, 1'($urandom));
            #1;
            model_check($sformatf("rand%0d", i));
            @(posedge CLK);
            model_edge();
            @(negedge CLK);
        end

        // async reset mid-cycle with entries queued
        for (int i = 0; i < 3; i++) begin
            drive(32'h500 + 32'(4 * i), 32'h3500 + 32'(i), 1'b1, 1'b0, 1'b0, 1'b0);
            #1;
            model_check($sformatf("prerst%0d", i));
            @(posedge CLK);
            model_edge();
            @(negedge CLK);
        end
        drive(32'h50C, 32'h350C, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        nRST = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, '0, '0, 1'b0, 0, 1'b0);
        model_q.delete();
        drive('0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        nRST = 1'b1;
        @(negedge CLK);
        #1;
        chk_all("post_rst", 1'b0, '0, '0, 1'b0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
